// File: rtl/ctech_lib_setb_release_seq.sv
// Active-low set generator: resynchronised power-on release, staggered per-domain setb release,
// and a four-phase soft-set pulse. Optional scan bypass: CTECH_LIB_SETB_RELEASE_SEQ_SCAN_BYPASS_EN.
module ctech_lib_setb_release_seq #(
  parameter int unsigned NUM_SYNC  = 2,
  parameter int unsigned NUM_DOM   = 4,
  parameter int unsigned GAP_CYC   = 4,
  parameter int unsigned PULSE_CYC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               soft_req,
`ifdef CTECH_LIB_SETB_RELEASE_SEQ_SCAN_BYPASS_EN
  input  logic               fscan_rstbypen,
  input  logic               fscan_byprst_b,
`endif
  output logic               soft_ack,
  output logic [NUM_DOM-1:0] setb,
  output logic               done
);

  localparam int unsigned GapW   = $clog2(GAP_CYC + 1);
  localparam int unsigned IdxW   = $clog2(NUM_DOM + 1);
  localparam int unsigned PulseW = $clog2(PULSE_CYC + 1);

  typedef enum logic [1:0] {StSync, StRel, StRun, StSoft} state_e;

  state_e              state_q, state_d;
  logic [NUM_SYNC-1:0] sync_q, sync_d;
  logic [NUM_DOM-1:0]  setb_q, setb_d;
  logic                done_q, done_d;
  logic                ack_q, ack_d;
  logic                pend_q, pend_d;
  logic [GapW-1:0]     gap_q, gap_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [PulseW-1:0]   pulse_q, pulse_d;

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[NUM_SYNC-2:0], 1'b1};
    setb_d  = setb_q;
    done_d  = done_q;
    ack_d   = ack_q;
    pend_d  = pend_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    pulse_d = pulse_q;

    if (ack_q && !soft_req) begin
      ack_d = 1'b0;
    end

    unique case (state_q)
      StSync: begin
        // Leave on the edge the synchronised release reaches the last stage.
        if (sync_d[NUM_SYNC-1] && !sync_q[NUM_SYNC-1]) begin
          state_d = StRel;
          gap_d   = '0;
          idx_d   = '0;
        end
      end
      StRel: begin
        if (gap_q == '0) begin
          for (int i = 0; i < int'(NUM_DOM); i++) begin
            if (idx_q == IdxW'(i)) begin
              setb_d[i] = 1'b1;
            end
          end
          gap_d = GapW'(GAP_CYC - 1);
          idx_d = idx_q + 1'b1;
          if (idx_q == IdxW'(NUM_DOM - 1)) begin
            done_d  = 1'b1;
            state_d = StRun;
            if (pend_q) begin
              ack_d  = 1'b1;
              pend_d = 1'b0;
            end
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      StRun: begin
        if (soft_req && !ack_q) begin
          state_d = StSoft;
          setb_d  = '0;
          done_d  = 1'b0;
          pend_d  = 1'b1;
          pulse_d = PulseW'(PULSE_CYC - 1);
        end
      end
      StSoft: begin
        // Soft set re-enters release directly; the clock domain is already live.
        if (pulse_q == '0) begin
          state_d = StRel;
          gap_d   = '0;
          idx_d   = '0;
        end else begin
          pulse_d = pulse_q - 1'b1;
        end
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StSync;
      sync_q  <= '0;
      setb_q  <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
      gap_q   <= '0;
      idx_q   <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      setb_q  <= setb_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      pulse_q <= pulse_d;
    end
  end

`ifdef CTECH_LIB_SETB_RELEASE_SEQ_SCAN_BYPASS_EN
  assign setb = fscan_rstbypen ? {NUM_DOM{fscan_byprst_b}} : setb_q;
`else
  assign setb = setb_q;
`endif
  assign done     = done_q;
  assign soft_ack = ack_q;

endmodule
